// File: rtl/pingpong_frame_buffer.sv
// Double-buffered frame store: a pixel stream fills one bank while the
// reader sees the other; banks swap atomically on frame completion.
module pingpong_frame_buffer #(
  parameter int PIXEL_W = 1,
  parameter int FRAME_W = 320,
  parameter int FRAME_H = 240,
  parameter int ADDR_W  = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PIXEL_W-1:0] pixel_in,
  input  logic               pixel_valid,
  input  logic               frame_start,
  input  logic               read_hold,
  input  logic               read_en,
  input  logic [ADDR_W-1:0]  read_addr,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               pixel_out_valid,
  output logic               has_frame,
  output logic               frame_ready,
  output logic               sync_err,
  output logic [7:0]         dropped_frames,
  output logic               wr_bank
);

  localparam int N  = FRAME_W * FRAME_H;
  localparam int MA = (N > 1) ? $clog2(N) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
  localparam logic [ADDR_W:0]   NV   = (ADDR_W + 1)'(N);

  logic [PIXEL_W-1:0] mem0 [N];
  logic [PIXEL_W-1:0] mem1 [N];

  logic [ADDR_W-1:0]  wr_addr;
  logic [ADDR_W-1:0]  waddr;
  logic               done;
  logic               swap;
  logic               drop;

  logic               s1_valid;
  logic               s1_ok;
  logic               s1_bank;
  logic [MA-1:0]      s1_idx;
  logic [PIXEL_W-1:0] rd;

  // frame_start pins the write to address 0, so it can never
  // coincide with completion unless the frame is one pixel long
  always_comb begin
    waddr = frame_start ? '0 : wr_addr;
    done  = pixel_valid && (waddr == LAST);
    swap  = done && !read_hold;
    drop  = done && read_hold;
  end

  always_ff @(posedge clk) begin
    if (pixel_valid && !wr_bank) mem0[waddr[MA-1:0]] <= pixel_in;
  end

  always_ff @(posedge clk) begin
    if (pixel_valid && wr_bank) mem1[waddr[MA-1:0]] <= pixel_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr        <= '0;
      wr_bank        <= 1'b0;
      has_frame      <= 1'b0;
      frame_ready    <= 1'b0;
      sync_err       <= 1'b0;
      dropped_frames <= 8'd0;
    end else begin
      frame_ready <= swap;
      sync_err    <= pixel_valid && frame_start && (wr_addr != '0);
      if (pixel_valid)
        wr_addr <= done ? '0 : waddr + ADDR_W'(1);
      if (swap) begin
        wr_bank   <= ~wr_bank;
        has_frame <= 1'b1;
      end
      if (drop && dropped_frames != 8'hff)
        dropped_frames <= dropped_frames + 8'd1;
    end
  end

  // bank and frame availability are frozen at request time
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_ok    <= 1'b0;
      s1_bank  <= 1'b0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= read_en;
      s1_ok    <= has_frame && ({1'b0, read_addr} < NV);
      s1_bank  <= ~wr_bank;
      s1_idx   <= read_addr[MA-1:0];
    end
  end

  always_comb begin
    rd = s1_bank ? mem1[s1_idx] : mem0[s1_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_out       <= '0;
      pixel_out_valid <= 1'b0;
    end else begin
      pixel_out_valid <= s1_valid;
      if (s1_valid)
        pixel_out <= s1_ok ? rd : '0;
    end
  end

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Directed bench for pingpong_frame_buffer: read table plus
// multi-cycle sequences for swap, hold, sync and reset corners.
module tb_pingpong_frame_buffer;

  localparam int PW = 8;
  localparam int FW = 16;
  localparam int FH = 4;
  localparam int AW = 7;
  localparam int N  = FW * FH;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] pixel_in;
  logic          pixel_valid;
  logic          frame_start;
  logic          read_hold;
  logic          read_en;
  logic [AW-1:0] read_addr;
  logic [PW-1:0] pixel_out;
  logic          pixel_out_valid;
  logic          has_frame;
  logic          frame_ready;
  logic          sync_err;
  logic [7:0]    dropped_frames;
  logic          wr_bank;

  int nerr = 0;
  int nchk = 0;
  int fr_cnt = 0;
  int f0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [PW-1:0] exp;
  } rd_vec_t;

  rd_vec_t tbl [6];

  pingpong_frame_buffer #(
    .PIXEL_W(PW), .FRAME_W(FW), .FRAME_H(FH), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pixel_in(pixel_in),
    .pixel_valid(pixel_valid),
    .frame_start(frame_start),
    .read_hold(read_hold),
    .read_en(read_en),
    .read_addr(read_addr),
    .pixel_out(pixel_out),
    .pixel_out_valid(pixel_out_valid),
    .has_frame(has_frame),
    .frame_ready(frame_ready),
    .sync_err(sync_err),
    .dropped_frames(dropped_frames),
    .wr_bank(wr_bank)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_ready) fr_cnt++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic wpix(input logic [PW-1:0] v, input logic fs);
    pixel_valid = 1'b1;
    pixel_in    = v;
    frame_start = fs;
    tick();
    pixel_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic write_frame(input logic [PW-1:0] xv);
    for (int j = 0; j < N; j++) wpix(PW'(j) ^ xv, j == 0);
  endtask

  task automatic read1(input string nm, input logic [AW-1:0] a,
                       input logic [PW-1:0] exp);
    read_en   = 1'b1;
    read_addr = a;
    tick();
    read_en = 1'b0;
    tick();
    chk({nm, "_valid"}, pixel_out_valid, 1);
    chk(nm, pixel_out, exp);
  endtask

  initial begin
    tbl[0] = '{7'd0,  8'd0};
    tbl[1] = '{7'd5,  8'd5};
    tbl[2] = '{7'd63, 8'd63};
    tbl[3] = '{7'd64, 8'd0};
    tbl[4] = '{7'd127, 8'd0};
    tbl[5] = '{7'd32, 8'd32};

    reset = 1'b1; pixel_in = '0; pixel_valid = 1'b0;
    frame_start = 1'b0; read_hold = 1'b0;
    read_en = 1'b0; read_addr = '0;
    tick(); tick();
    reset = 1'b0;

    // 1: reset state and read latency with no frame
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_has_frame", has_frame, 0);
    chk("rst_dropped", dropped_frames, 0);
    chk("rst_out_valid", pixel_out_valid, 0);
    read_en = 1'b1; read_addr = 7'd5;
    tick();
    read_en = 1'b0;
    chk("t1_lat1_valid", pixel_out_valid, 0);
    tick();
    chk("t1_lat2_valid", pixel_out_valid, 1);
    chk("t1_lat2_data", pixel_out, 0);
    tick();
    chk("t1_idle_valid", pixel_out_valid, 0);

    // 2: first frame, value = address
    f0 = fr_cnt;
    write_frame(8'h00);
    chk("t2_frame_ready", fr_cnt - f0, 1);
    chk("t2_wr_bank", wr_bank, 1);
    chk("t2_has_frame", has_frame, 1);
    for (int i = 0; i <= 65; i++) begin
      read_en   = 1'b1;
      read_addr = AW'(i);
      tick();
      if (i >= 1) chk("t2_stream", pixel_out, (i - 1 < N) ? i - 1 : 0);
    end
    read_en = 1'b0;
    tick();
    chk("t2_stream_oob", pixel_out, 0);
    foreach (tbl[k]) read1("t2_table", tbl[k].addr, tbl[k].exp);

    // 3: second frame written during continuous reads
    f0 = fr_cnt;
    for (int j = 0; j < N; j++) begin
      pixel_valid = 1'b1;
      pixel_in    = PW'(j) ^ 8'hff;
      frame_start = (j == 0);
      read_en     = 1'b1;
      read_addr   = AW'(j);
      tick();
      if (j >= 1) chk("t3_old_frame", pixel_out, j - 1);
    end
    pixel_valid = 1'b0; frame_start = 1'b0;
    read_addr = 7'd10;
    tick();
    chk("t3_swap_cycle_read", pixel_out, 63);
    chk("t3_frame_ready", fr_cnt - f0, 1);
    chk("t3_wr_bank", wr_bank, 0);
    read_en = 1'b0;
    tick();
    chk("t3_new_frame", pixel_out, 245);

    // 4: reader hold across three completions
    read_hold = 1'b1;
    f0 = fr_cnt;
    for (int k = 0; k < 3; k++) write_frame(8'haa);
    chk("t4_no_ready", fr_cnt - f0, 0);
    chk("t4_wr_bank", wr_bank, 0);
    chk("t4_dropped", dropped_frames, 3);
    read1("t4_held_read", 7'd3, 8'd252);
    read_hold = 1'b0;
    write_frame(8'h5a);
    chk("t4_release_ready", fr_cnt - f0, 1);
    chk("t4_release_bank", wr_bank, 1);
    chk("t4_dropped_keep", dropped_frames, 3);
    read1("t4_release_read", 7'd7, 8'h5d);

    // 5: frame_start truncating a partial frame at address 20
    for (int j = 0; j < 20; j++) wpix(PW'(j) ^ 8'h33, j == 0);
    chk("t5_no_err_yet", sync_err, 0);
    wpix(8'h77, 1'b1);
    chk("t5_sync_err", sync_err, 1);
    tick();
    chk("t5_sync_err_end", sync_err, 0);
    f0 = fr_cnt;
    for (int k = 1; k < N - 1; k++) wpix(PW'(k) ^ 8'h33, 1'b0);
    chk("t5_no_early_swap", wr_bank, 1);
    chk("t5_no_early_ready", fr_cnt - f0, 0);
    wpix(8'(N - 1) ^ 8'h33, 1'b0);
    chk("t5_swap_ready", fr_cnt - f0, 1);
    chk("t5_swap_bank", wr_bank, 0);
    read1("t5_addr0", 7'd0, 8'h77);
    read1("t5_addr20", 7'd20, 8'h27);
    read1("t5_addr5", 7'd5, 8'h36);

    // 6: reset mid-frame with a read in flight
    for (int j = 0; j < 30; j++) wpix(PW'(j), j == 0);
    read_en = 1'b1; read_addr = 7'd20;
    tick();
    read_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_out_valid", pixel_out_valid, 0);
    chk("t6_out", pixel_out, 0);
    chk("t6_wr_bank", wr_bank, 0);
    chk("t6_has_frame", has_frame, 0);
    chk("t6_dropped", dropped_frames, 0);
    chk("t6_frame_ready", frame_ready, 0);
    chk("t6_sync_err", sync_err, 0);
    tick();
    chk("t6_flushed", pixel_out_valid, 0);
    read1("t6_no_frame_read", 7'd20, 8'd0);
    for (int j = 0; j < N - 1; j++) wpix(PW'(j) ^ 8'h11, 1'b0);
    chk("t6_addr_from_zero", wr_bank, 0);
    wpix(8'(N - 1) ^ 8'h11, 1'b0);
    chk("t6_swap_bank", wr_bank, 1);
    chk("t6_has_frame_new", has_frame, 1);
    read1("t6_read", 7'd9, 8'h18);

    // 7: idle gap with ignored frame_start mid-frame
    for (int j = 0; j < 30; j++) wpix(PW'(j) ^ 8'hc3, j == 0);
    frame_start = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    frame_start = 1'b0;
    chk("t7_gap_no_err", sync_err, 0);
    f0 = fr_cnt;
    for (int j = 30; j < N - 1; j++) wpix(PW'(j) ^ 8'hc3, 1'b0);
    chk("t7_no_early_swap", wr_bank, 1);
    wpix(8'(N - 1) ^ 8'hc3, 1'b0);
    chk("t7_ready", fr_cnt - f0, 1);
    chk("t7_bank", wr_bank, 0);
    read1("t7_addr30", 7'd30, 8'hdd);
    read1("t7_addr29", 7'd29, 8'hde);

    // dropped counter saturation
    read_hold = 1'b1;
    for (int k = 0; k < 254; k++) write_frame(8'h00);
    chk("sat_254", dropped_frames, 254);
    for (int k = 0; k < 2; k++) write_frame(8'h00);
    chk("sat_255", dropped_frames, 255);
    chk("sat_bank", wr_bank, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
